alt_pattern_checker: RTL and testbench

Receiver-side checker for the alternating-bit test word produced by the per-bit generate-loop pattern writer: bit j of the reference word is j%2, so the word is 0xAAAAAAAA for W=32. The checker samples a valid-qualified word stream and acquires lock on the pattern with a HUNT/LOCKED state machine. Once locked, it accumulates sticky per-bit error flags and a saturating error count. It sits at the receive end of the test datapath and feeds status registers.

---
 rtl/alt_pattern_checker.sv | 89 ++++++++
 tb/tb_alt_pattern_checker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alt_pattern_checker.sv
// alt_pattern_checker: locks onto the alternating-bit test word and tracks sticky per-bit errors and a saturating error count.
module alt_pattern_checker #(
    parameter int W          = 32,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 c,
    input  logic                 r,
    input  logic                 d_valid,
    input  logic [W-1:0]         d,
    input  logic                 clr,
    output logic                 locked,
    output logic                 mismatch,
    output logic [W-1:0]         err_bits,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t                 state;
    logic [W-1:0]           exp_w;
    logic [W-1:0]           diff;
    logic [W-1:0]           bits_base;
    logic [ERR_CNT_W-1:0]   cnt_base;
    logic [ERR_CNT_W-1:0]   cnt_next;
    logic [GW-1:0]          good_run;
    logic [UW-1:0]          bad_run;
    logic                   good;
    logic                   bad;
    logic                   capture;
    genvar j;
    for (j = 0; j < W; j++) begin : g_exp
        assign exp_w[j] = (j % 2) == 1;
    end
    always_comb begin
        diff      = d ^ exp_w;
        good      = d_valid && (diff == '0);
        bad       = d_valid && (diff != '0);
        capture   = bad && (state == LOCKED);
        bits_base = clr ? '0 : err_bits;
        cnt_base  = clr ? '0 : err_cnt;
        cnt_next  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
    end
    always_ff @(posedge c) begin
        if (r) begin
            state    <= HUNT;
            locked   <= 1'b0;
            mismatch <= 1'b0;
            err_bits <= '0;
            err_cnt  <= '0;
            good_run <= '0;
            bad_run  <= '0;
        end else begin
            mismatch <= bad;
            // the word that unlocks is still captured, and clr never drops it
            if (capture) begin
                err_bits <= bits_base | diff;
                err_cnt  <= cnt_next;
            end else if (clr) begin
                err_bits <= '0;
                err_cnt  <= '0;
            end
            if (state == HUNT) begin
                if (good && good_run == GW'(LOCK_CNT - 1)) begin
                    state    <= LOCKED;
                    locked   <= 1'b1;
                    good_run <= '0;
                    bad_run  <= '0;
                end else if (good) begin
                    good_run <= good_run + 1'b1;
                end else if (bad) begin
                    good_run <= '0;
                end
            end else begin
                if (bad && bad_run == UW'(UNLOCK_CNT - 1)) begin
                    state    <= HUNT;
                    locked   <= 1'b0;
                    good_run <= '0;
                    bad_run  <= '0;
                end else if (bad) begin
                    bad_run <= bad_run + 1'b1;
                end else if (good) begin
                    bad_run <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alt_pattern_checker.sv
// tb_alt_pattern_checker: directed stimulus with a behavioural model, checked every cycle on two counter widths.
module tb_alt_pattern_checker;
    localparam logic [31:0] EXP = 32'hAAAAAAAA;
    logic        c = 1'b0;
    logic        r = 1'b1;
    logic        d_valid = 1'b0;
    logic [31:0] d = '0;
    logic        clr = 1'b0;
    logic        locked, mismatch, locked4, mismatch4;
    logic [31:0] err_bits, err_bits4;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt4;
    int n_chk = 0;
    int n_fail = 0;
    bit started = 0;
    bit          m_locked = 0;
    bit          m_mis = 0;
    logic [31:0] m_bits = '0;
    int          m_cnt16 = 0;
    int          m_cnt4 = 0;
    int          g_run = 0;
    int          b_run = 0;

    alt_pattern_checker dut (
        .c(c), .r(r), .d_valid(d_valid), .d(d), .clr(clr),
        .locked(locked), .mismatch(mismatch), .err_bits(err_bits), .err_cnt(err_cnt)
    );
    alt_pattern_checker #(.ERR_CNT_W(4)) dut4 (
        .c(c), .r(r), .d_valid(d_valid), .d(d), .clr(clr),
        .locked(locked4), .mismatch(mismatch4), .err_bits(err_bits4), .err_cnt(err_cnt4)
    );

    always #5 c = ~c;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // model: what the outputs must show after each edge
    always @(posedge c) begin
        if (r) begin
            m_locked = 0; m_mis = 0; m_bits = '0; m_cnt16 = 0; m_cnt4 = 0; g_run = 0; b_run = 0;
            started = 1;
        end else begin
            m_mis = d_valid && d != EXP;
            if (m_mis && m_locked) begin
                m_bits  = (clr ? 32'h0 : m_bits) | (d ^ EXP);
                m_cnt16 = (clr ? 0 : m_cnt16) + 1;
                m_cnt4  = (clr ? 0 : m_cnt4) + 1;
                if (m_cnt16 > 65535) m_cnt16 = 65535;
                if (m_cnt4 > 15) m_cnt4 = 15;
            end else if (clr) begin
                m_bits = '0; m_cnt16 = 0; m_cnt4 = 0;
            end
            if (d_valid) begin
                if (!m_locked) begin
                    g_run = m_mis ? 0 : g_run + 1;
                    if (g_run == 4) begin m_locked = 1; g_run = 0; b_run = 0; end
                end else begin
                    b_run = m_mis ? b_run + 1 : 0;
                    if (b_run == 2) begin m_locked = 0; g_run = 0; b_run = 0; end
                end
            end
        end
    end

    always @(negedge c) begin
        if (started) begin
            chk("locked", 64'(locked), 64'(m_locked));
            chk("mismatch", 64'(mismatch), 64'(m_mis));
            chk("err_bits", 64'(err_bits), 64'(m_bits));
            chk("err_cnt", 64'(err_cnt), 64'(m_cnt16));
            chk("locked4", 64'(locked4), 64'(m_locked));
            chk("mismatch4", 64'(mismatch4), 64'(m_mis));
            chk("err_bits4", 64'(err_bits4), 64'(m_bits));
            chk("err_cnt4", 64'(err_cnt4), 64'(m_cnt4));
        end
    end

    task automatic step(input logic v, input logic [31:0] w, input logic cl);
        d_valid = v; d = w; clr = cl;
        @(posedge c); #1;
        d_valid = 1'b0; clr = 1'b0;
    endtask

    initial begin
        step(0, '0, 0);
        step(0, '0, 0);
        r = 1'b0;
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_cnt", 64'(err_cnt), 64'd0);
        for (int i = 0; i < 3; i++) step(1, EXP, 0);
        chk("lock_early", 64'(locked), 64'd0);
        step(1, EXP, 0);
        chk("lock_4th", 64'(locked), 64'd1);
        chk("lock_cnt0", 64'(err_cnt), 64'd0);
        r = 1'b1; step(0, '0, 0); r = 1'b0;
        for (int i = 0; i < 3; i++) step(1, EXP, 0);
        step(1, 32'hAAAAAAAB, 0);
        chk("hunt_mis", 64'(mismatch), 64'd1);
        chk("hunt_bits", 64'(err_bits), 64'd0);
        for (int i = 0; i < 3; i++) begin step(1, EXP, 0); step(0, '0, 0); end
        chk("hunt_relock_early", 64'(locked), 64'd0);
        step(1, EXP, 0);
        chk("hunt_relock", 64'(locked), 64'd1);
        step(1, 32'hAAAAAAAB, 0);
        step(1, EXP, 0);
        chk("lk_bits", 64'(err_bits), 64'h1);
        chk("lk_cnt", 64'(err_cnt), 64'd1);
        chk("lk_locked", 64'(locked), 64'd1);
        step(1, 32'h55555555, 0);
        chk("lk_stay", 64'(locked), 64'd1);
        step(1, 32'h55555555, 0);
        chk("unlock", 64'(locked), 64'd0);
        chk("unlock_bits", 64'(err_bits), 64'hFFFFFFFF);
        chk("unlock_cnt", 64'(err_cnt), 64'd3);
        for (int i = 0; i < 4; i++) step(1, EXP, 0);
        step(0, '0, 1);
        for (int i = 0; i < 20; i++) begin step(1, 32'h2AAAAAAA, 0); step(1, EXP, 0); end
        chk("sat_locked", 64'(locked4), 64'd1);
        chk("sat_cnt4", 64'(err_cnt4), 64'd15);
        chk("sat_cnt16", 64'(err_cnt), 64'd20);
        chk("sat_bits", 64'(err_bits4), 64'h80000000);
        step(0, '0, 1);
        for (int i = 0; i < 5; i++) begin step(1, 32'hAAAAAAA5, 0); step(1, EXP, 0); end
        chk("pre_clr_cnt", 64'(err_cnt), 64'd5);
        chk("pre_clr_bits", 64'(err_bits), 64'hF);
        step(1, 32'h2AAAAAAA, 1);
        chk("clr_cap_bits", 64'(err_bits), 64'h80000000);
        chk("clr_cap_cnt", 64'(err_cnt), 64'd1);
        chk("clr_cap_locked", 64'(locked), 64'd1);
        step(0, '0, 1);
        chk("clr_bits", 64'(err_bits), 64'd0);
        chk("clr_cnt", 64'(err_cnt), 64'd0);
        step(1, 32'hAAAAAAAB, 0);
        step(1, EXP, 0);
        r = 1'b1;
        step(1, 32'h55555555, 0);
        r = 1'b0;
        chk("mr_locked", 64'(locked), 64'd0);
        chk("mr_mis", 64'(mismatch), 64'd0);
        chk("mr_bits", 64'(err_bits), 64'd0);
        chk("mr_cnt", 64'(err_cnt), 64'd0);
        for (int i = 0; i < 3; i++) step(1, EXP, 0);
        chk("mr_relock_early", 64'(locked), 64'd0);
        step(1, EXP, 0);
        chk("mr_relock", 64'(locked), 64'd1);
        @(negedge c); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
